// File: rtl/vending_machine_multi_pkg.sv
// rtl/vending_machine_multi_pkg.sv - coin/change codes, FSM states and coin valuation for the vending controller
package vm_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_20   = 2'b11;

   localparam logic [1:0] CHG_NONE  = 2'b00;
   localparam logic [1:0] CHG_5     = 2'b01;
   localparam logic [1:0] CHG_10    = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } vm_state_t;

   // Change codes share the coin encoding, so this also values a change coin.
   function automatic logic [4:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  coin_value = 5'd5;
         COIN_10: coin_value = 5'd10;
         COIN_20: coin_value = 5'd20;
         default: coin_value = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// rtl/vending_machine_multi_if.sv - coin acceptor / dispenser signal bundle with front-end and controller views
interface vending_machine_multi_if #(
   parameter int SEL_W    = 2,
   parameter int CREDIT_W = 8
);
   logic [1:0]          in;
   logic                buy;
   logic [SEL_W-1:0]    sel;
   logic                cancel;
   logic                out;
   logic [SEL_W-1:0]    item;
   logic [1:0]          change;
   logic [CREDIT_W-1:0] credit;
   logic                busy;
   logic                coin_reject;
   logic                sold_out;

   modport master (
      output in, buy, sel, cancel,
      input  out, item, change, credit, busy, coin_reject, sold_out
   );

   modport slave (
      input  in, buy, sel, cancel,
      output out, item, change, credit, busy, coin_reject, sold_out
   );
endinterface

// File: rtl/vending_machine_multi_change_dispenser.sv
// rtl/vending_machine_multi_change_dispenser.sv - serial change emitter, largest coin first, one coin per cycle
module vm_change_dispenser
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [CREDIT_W-1:0] amount,
   output logic [1:0]          change,
   output logic                done
);
   logic [CREDIT_W-1:0] remaining;
   logic [CREDIT_W-1:0] src;
   logic [1:0]          code;

   always_comb begin
      src = load ? amount : remaining;
      if (src >= CREDIT_W'(10))
         code = CHG_10;
      else if (src != '0)
         code = CHG_5;
      else
         code = CHG_NONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         change    <= CHG_NONE;
      end else begin
         change    <= code;
         remaining <= src - CREDIT_W'(coin_value(code));
      end
   end

   // Set while the coin now on the output is the last one owed.
   assign done = (remaining == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-item vending controller; define VM_STOCK_EN for per-item stock counters
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int                            NUM_ITEMS  = 4,
   parameter int                            SEL_W      = 2,
   parameter int                            CREDIT_W   = 8,
   parameter int                            MAX_CREDIT = 100,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd15},
   parameter int                            STOCK_INIT = 3
) (
   input logic                   clk,
   input logic                   rst,
   vending_machine_multi_if.slave bus
);
   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

   vm_state_t           state, state_n;
   logic [CREDIT_W-1:0] credit, credit_n, coin_sum, price;
   logic [SEL_W-1:0]    item_r, item_n;
   logic                out_r, out_n, busy_r, busy_n, reject_r, reject_n, sold_r, sold_n;
   logic                sel_ok, stock_ok, funds_ok, coin_in, load, take, done;
   logic [1:0]          change_w;

`ifdef VM_STOCK_EN
   localparam int STOCK_W = $clog2(STOCK_INIT + 1);
   logic [STOCK_W-1:0] stock [NUM_ITEMS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (take) begin
         for (int i = 0; i < NUM_ITEMS; i++)
            if (bus.sel == SEL_W'(i)) stock[i] <= stock[i] - STOCK_W'(1);
      end
   end
`endif

   always_comb begin
      price    = '0;
      sel_ok   = 1'b0;
      stock_ok = 1'b1;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            price  = PRICES[i*CREDIT_W +: CREDIT_W];
            sel_ok = 1'b1;
`ifdef VM_STOCK_EN
            stock_ok = (stock[i] != '0);
`endif
         end
      end
   end

   always_comb begin
      state_n  = state;
      credit_n = credit;
      out_n    = 1'b0;
      item_n   = '0;
      reject_n = 1'b0;
      sold_n   = 1'b0;
      load     = 1'b0;
      take     = 1'b0;
      coin_in  = (bus.in != COIN_NONE);
      coin_sum = credit + CREDIT_W'(coin_value(bus.in));
      funds_ok = sel_ok && (credit >= price);
      case (state)
         S_IDLE, S_COLLECT: begin
            if (bus.cancel && credit != '0) begin
               state_n  = S_CHANGE;
               load     = 1'b1;
               reject_n = coin_in;
            end else if (bus.buy && funds_ok && stock_ok) begin
               state_n  = S_VEND;
               credit_n = credit - price;
               out_n    = 1'b1;
               item_n   = bus.sel;
               take     = 1'b1;
               reject_n = coin_in;
            end else begin
               // A refused buy leaves the coin path free to credit this cycle's coin.
               sold_n = bus.buy && funds_ok && !stock_ok;
               if (coin_in) begin
                  if (coin_sum > MAX_C) begin
                     reject_n = 1'b1;
                  end else begin
                     credit_n = coin_sum;
                     state_n  = S_COLLECT;
                  end
               end
            end
         end
         S_VEND: begin
            reject_n = coin_in;
            if (credit != '0) begin
               state_n = S_CHANGE;
               load    = 1'b1;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_CHANGE: begin
            reject_n = coin_in;
            credit_n = credit - CREDIT_W'(coin_value(change_w));
            if (done) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         credit   <= '0;
         out_r    <= 1'b0;
         item_r   <= '0;
         busy_r   <= 1'b0;
         reject_r <= 1'b0;
         sold_r   <= 1'b0;
      end else begin
         state    <= state_n;
         credit   <= credit_n;
         out_r    <= out_n;
         item_r   <= item_n;
         busy_r   <= busy_n;
         reject_r <= reject_n;
         sold_r   <= sold_n;
      end
   end

   vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .amount (credit),
      .change (change_w),
      .done   (done)
   );

   assign bus.out         = out_r;
   assign bus.item        = item_r;
   assign bus.change      = change_w;
   assign bus.credit      = credit;
   assign bus.busy        = busy_r;
   assign bus.coin_reject = reject_r;
   assign bus.sold_out    = sold_r;

endmodule
